pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central controller for the 5-stage RISC-V core. It sequences boot-loading of the instruction memory and generates the per-cycle enables and mux selects for the IF/ID/IE datapath. It detects load-use hazards (stall) and resolved branches/jumps (redirect plus flush), and drains the pipeline on halt. It sits beside the core datapath in the top level and drives every control bit that the datapath previously left undriven.

## Interface
- IMEM_DEPTH, 2048, instruction words in IMEM
- ADDR_W, 11, IMEM word-address width; must equal clog2(IMEM_DEPTH)
- DRAIN_CYCLES, 3, cycles spent in DRAIN before HALT (pipeline depth past IF)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- load_req  in  1  start IMEM boot-load (honoured in IDLE/HALT only)
- load_valid  in  1  loader word present this cycle
- load_last  in  1  final loader word, qualified by load_valid
- load_ready  out  1  controller accepts a loader word
- load_addr  out  ADDR_W  IMEM write address for the current word
- load_done  out  1  one-cycle pulse on LOAD→RUN
- halt_req  in  1  request stop (ecall/external)
- id_rs1_addr, id_rs2_addr  in  5 each  source registers in ID
- ie_rd_addr  in  5  destination register in IE
- ie_is_load  in  1  IE instruction is a load
- ie_opcode  in  7  IE opcode
- ie_funct3  in  3  IE funct3
- eq_flag, neq_flag, lt_flag, ge_flag, ltu_flag, geu_flag  in  1 each  branch_cmp results, valid in the same cycle as ie_opcode
- pc_en, imem_en, imem_ld, rf_en, branchcmp_en  out  1 each  datapath enables
- branch  out  1  PC loads ALU target this cycle
- ie_mux1_sel  out  1  1=PC, 0=rs1
- ie_mux2_sel  out  1  1=immediate, 0=rs2
- id_flush, ie_flush  out  1 each  load bubble into ID/IE register at next edge
- stall  out  1  hold PC and ID register
- state  out  3  current FSM state (debug)
- perf_stalls, perf_flushes  out  32 each  performance counters (see Configuration)

## Operation
- FSM states: IDLE, LOAD, RUN, DRAIN, HALT.
- IDLE: all enables 0. On load_req, go to LOAD and clear load_addr.
- LOAD: load_ready=imem_ld=imem_en=1. Each load_valid advances load_addr by 1.
  - load_valid with load_last, or with load_addr==IMEM_DEPTH-1, moves to RUN and pulses load_done.
  - load_req deasserting in LOAD has no effect.
- RUN: imem_en=rf_en=branchcmp_en=1. pc_en=!stall.
- Taken condition: BRANCH (1100011) with funct3 000/001/100/101/110/111 selecting EQ/NEQ/LT/GE/LTU/GEU. JAL (1101111) and JALR (1100111) are always taken.
- Taken: branch=1, pc_en=1, id_flush=ie_flush=1 in that cycle.
- Stall: ie_is_load && ie_rd_addr!=0 && ie_rd_addr matches id_rs1_addr or id_rs2_addr. Drives stall=1, pc_en=0, ie_flush=1.
- Taken branch overrides stall; stall is 0 in that cycle.
- Mux selects, decoded from ie_opcode, valid in every state:
  - ie_mux1_sel=1 for BRANCH, JAL, AUIPC (0010111).
  - ie_mux2_sel=0 only for R-type (0110011), 1 otherwise.
- halt_req in RUN moves to DRAIN. A taken branch in the same cycle still pulses branch with pc_en=1.
- DRAIN: pc_en=0, imem_en=0, rf_en=1. After DRAIN_CYCLES cycles, go to HALT.
- HALT: all enables 0. load_req returns to LOAD. halt_req and load_req are ignored in all other states.

## Timing
- Reset (async assert, sync deassert): state=IDLE, load_addr=0. All outputs 0 except the opcode-decoded mux selects. Counters=0.
- Branch/stall decisions are combinational from IE inputs in the same cycle; the datapath acts at the next edge.
- Branch penalty: 2 bubbles. Load-use penalty: 1 bubble.
- load_addr is registered. The first word is written at address 0 in the first LOAD cycle with load_valid.
- load_done is high in the first RUN cycle.
- Reset mid-LOAD or mid-DRAIN aborts immediately: imem_ld drops asynchronously.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - perf_stalls counts cycles with stall=1.
  - perf_flushes counts cycles with branch=1.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Package pipeline_ctrl_pkg holds:
  - the state enum (3-bit);
  - opcode constants: BRANCH, JAL, JALR, AUIPC, OP, LOAD;
  - funct3 branch constants.
- One sub-module, hazard_unit: combinational stall/taken/flush logic.
- The FSM, load counter, drain counter and performance counters live in pipeline_ctrl.

## Test plan
- Reset, then load_req and 4 words with load_last on the 4th: load_addr 0..3, load_done pulses once, state=RUN.
- Streaming IMEM_DEPTH words without load_last: auto-exit at address 2047 into RUN.
- Load writing x5 in IE while the ID instruction reads x5: one cycle of stall=1, pc_en=0, ie_flush=1. With rd=x0: no stall.
- BEQ in IE with eq_flag=1: branch=1, id_flush=ie_flush=1. Same with eq_flag=0: no branch. funct3=110 with ltu_flag=1: taken.
- halt_req together with a JAL in IE: branch pulses, DRAIN lasts 3 cycles, then HALT. load_req then re-enters LOAD.
- rst_n asserted while LOAD is at address 10: imem_ld=0 and load_addr=0 immediately. With PIPE_CTRL_PERF_EN, counters read 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
package pipeline_ctrl_pkg;

   localparam int unsigned IMEM_DEPTH   = 2048;
   localparam int unsigned ADDR_W       = $clog2(IMEM_DEPTH);
   localparam int unsigned DRAIN_CYCLES = 3;
   localparam int unsigned DRAIN_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam int unsigned OPC_W        = 7;
   localparam int unsigned F3_W         = 3;
   localparam int unsigned REG_W        = 5;
   localparam int unsigned PERF_W       = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_HALT  = 3'd4
   } state_e;

   localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
   localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;

   localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
   localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
   localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
   localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
   localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
   localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Boot-loader handshake between the IMEM loader and the controller.
interface pipeline_ctrl_if;
   import pipeline_ctrl_pkg::*;

   logic              load_req;
   logic              load_valid;
   logic              load_last;
   logic              load_ready;
   logic [ADDR_W-1:0] load_addr;
   logic              load_done;

   modport master (
      output load_req, load_valid, load_last,
      input  load_ready, load_addr, load_done
   );

   modport slave (
      input  load_req, load_valid, load_last,
      output load_ready, load_addr, load_done
   );

endinterface

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Combinational branch-resolution and load-use hazard detection for IE/ID.
module hazard_unit
   import pipeline_ctrl_pkg::*;
(
   input  logic             active,
   input  logic [OPC_W-1:0] ie_opcode,
   input  logic [F3_W-1:0]  ie_funct3,
   input  logic             eq_flag,
   input  logic             neq_flag,
   input  logic             lt_flag,
   input  logic             ge_flag,
   input  logic             ltu_flag,
   input  logic             geu_flag,
   input  logic [REG_W-1:0] id_rs1_addr,
   input  logic [REG_W-1:0] id_rs2_addr,
   input  logic [REG_W-1:0] ie_rd_addr,
   input  logic             ie_is_load,
   output logic             taken_c,
   output logic             stall_c,
   output logic             id_flush_c,
   output logic             ie_flush_c
);

   logic cond_c;
   logic load_use_c;

   // Branch condition select; reserved funct3 codes never take.
   always_comb begin
      cond_c = 1'b0;
      case (ie_funct3)
         F3_BEQ:  cond_c = eq_flag;
         F3_BNE:  cond_c = neq_flag;
         F3_BLT:  cond_c = lt_flag;
         F3_BGE:  cond_c = ge_flag;
         F3_BLTU: cond_c = ltu_flag;
         F3_BGEU: cond_c = geu_flag;
         default: cond_c = 1'b0;
      endcase
   end

   // Taken redirect wins over a load-use stall in the same cycle.
   always_comb begin
      load_use_c = ie_is_load && (ie_rd_addr != '0) &&
                   ((ie_rd_addr == id_rs1_addr) || (ie_rd_addr == id_rs2_addr));
      taken_c    = active && (((ie_opcode == OPC_BRANCH) && cond_c) ||
                              (ie_opcode == OPC_JAL) || (ie_opcode == OPC_JALR));
      stall_c    = active && load_use_c && !taken_c;
      id_flush_c = taken_c;
      ie_flush_c = taken_c || stall_c;
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: IMEM boot-load sequencing, run/drain/halt FSM and
// datapath enables. Optional perf counters under PIPE_CTRL_PERF_EN.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   pipeline_ctrl_if.slave     ldr,
   input  logic               halt_req,
   input  logic [REG_W-1:0]   id_rs1_addr,
   input  logic [REG_W-1:0]   id_rs2_addr,
   input  logic [REG_W-1:0]   ie_rd_addr,
   input  logic               ie_is_load,
   input  logic [OPC_W-1:0]   ie_opcode,
   input  logic [F3_W-1:0]    ie_funct3,
   input  logic               eq_flag,
   input  logic               neq_flag,
   input  logic               lt_flag,
   input  logic               ge_flag,
   input  logic               ltu_flag,
   input  logic               geu_flag,
   output logic               pc_en,
   output logic               imem_en,
   output logic               imem_ld,
   output logic               rf_en,
   output logic               branchcmp_en,
   output logic               branch,
   output logic               ie_mux1_sel,
   output logic               ie_mux2_sel,
   output logic               id_flush,
   output logic               ie_flush,
   output logic               stall,
   output logic [2:0]         state,
   output logic [PERF_W-1:0]  perf_stalls,
   output logic [PERF_W-1:0]  perf_flushes
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   load_addr_q, load_addr_d;
   logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
   logic                load_done_q, load_done_d;
   logic                taken_c, stall_c, id_flush_c, ie_flush_c;

   hazard_unit u_hazard (
      .active      (state_q == ST_RUN),
      .ie_opcode   (ie_opcode),
      .ie_funct3   (ie_funct3),
      .eq_flag     (eq_flag),
      .neq_flag    (neq_flag),
      .lt_flag     (lt_flag),
      .ge_flag     (ge_flag),
      .ltu_flag    (ltu_flag),
      .geu_flag    (geu_flag),
      .id_rs1_addr (id_rs1_addr),
      .id_rs2_addr (id_rs2_addr),
      .ie_rd_addr  (ie_rd_addr),
      .ie_is_load  (ie_is_load),
      .taken_c     (taken_c),
      .stall_c     (stall_c),
      .id_flush_c  (id_flush_c),
      .ie_flush_c  (ie_flush_c)
   );

   // State, load address, drain counter and load_done pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         load_addr_q <= '0;
         drain_cnt_q <= '0;
         load_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         load_addr_q <= load_addr_d;
         drain_cnt_q <= drain_cnt_d;
         load_done_q <= load_done_d;
      end
   end

   // Next-state and per-state datapath enables.
   always_comb begin
      state_d        = state_q;
      load_addr_d    = load_addr_q;
      drain_cnt_d    = drain_cnt_q;
      load_done_d    = 1'b0;
      pc_en          = 1'b0;
      imem_en        = 1'b0;
      imem_ld        = 1'b0;
      rf_en          = 1'b0;
      branchcmp_en   = 1'b0;
      branch         = 1'b0;
      id_flush       = 1'b0;
      ie_flush       = 1'b0;
      stall          = 1'b0;
      ldr.load_ready = 1'b0;

      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (ldr.load_req) begin
               state_d     = ST_LOAD;
               load_addr_d = '0;
            end
         end
         ST_LOAD: begin
            ldr.load_ready = 1'b1;
            imem_ld        = 1'b1;
            imem_en        = 1'b1;
            if (ldr.load_valid) begin
               load_addr_d = load_addr_q + ADDR_W'(1);
               if (ldr.load_last || (load_addr_q == ADDR_W'(IMEM_DEPTH - 1))) begin
                  state_d     = ST_RUN;
                  load_done_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            imem_en      = 1'b1;
            rf_en        = 1'b1;
            branchcmp_en = 1'b1;
            branch       = taken_c;
            stall        = stall_c;
            id_flush     = id_flush_c;
            ie_flush     = ie_flush_c;
            pc_en        = !stall_c;
            if (halt_req) begin
               state_d     = ST_DRAIN;
               drain_cnt_d = '0;
            end
         end
         ST_DRAIN: begin
            rf_en = 1'b1;
            if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
               state_d = ST_HALT;
            end else begin
               drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Operand mux selects decoded from the IE opcode in every state.
   assign ie_mux1_sel   = (ie_opcode == OPC_BRANCH) || (ie_opcode == OPC_JAL) ||
                          (ie_opcode == OPC_AUIPC);
   assign ie_mux2_sel   = (ie_opcode != OPC_OP);
   assign state         = state_q;
   assign ldr.load_addr = load_addr_q;
   assign ldr.load_done = load_done_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [PERF_W-1:0] perf_stalls_q, perf_flushes_q;

   // Saturating stall and branch-redirect counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stalls_q  <= '0;
         perf_flushes_q <= '0;
      end else begin
         if (stall && (perf_stalls_q != '1))
            perf_stalls_q <= perf_stalls_q + PERF_W'(1);
         if (branch && (perf_flushes_q != '1))
            perf_flushes_q <= perf_flushes_q + PERF_W'(1);
      end
   end

   assign perf_stalls  = perf_stalls_q;
   assign perf_flushes = perf_flushes_q;
`else
   assign perf_stalls  = '0;
   assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed, table-driven bench for pipeline_ctrl.
module tb_pipeline_ctrl;
   import pipeline_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic halt_req;
   logic [4:0] id_rs1_addr, id_rs2_addr, ie_rd_addr;
   logic ie_is_load;
   logic [6:0] ie_opcode;
   logic [2:0] ie_funct3;
   logic eq_flag, neq_flag, lt_flag, ge_flag, ltu_flag, geu_flag;
   logic pc_en, imem_en, imem_ld, rf_en, branchcmp_en, branch;
   logic ie_mux1_sel, ie_mux2_sel, id_flush, ie_flush, stall;
   logic [2:0] state;
   logic [31:0] perf_stalls, perf_flushes;

   int checks = 0;
   int failures = 0;

   pipeline_ctrl_if ldr ();

   pipeline_ctrl dut (
      .clk(clk), .rst_n(rst_n), .ldr(ldr), .halt_req(halt_req),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .ie_rd_addr(ie_rd_addr), .ie_is_load(ie_is_load),
      .ie_opcode(ie_opcode), .ie_funct3(ie_funct3),
      .eq_flag(eq_flag), .neq_flag(neq_flag), .lt_flag(lt_flag),
      .ge_flag(ge_flag), .ltu_flag(ltu_flag), .geu_flag(geu_flag),
      .pc_en(pc_en), .imem_en(imem_en), .imem_ld(imem_ld), .rf_en(rf_en),
      .branchcmp_en(branchcmp_en), .branch(branch),
      .ie_mux1_sel(ie_mux1_sel), .ie_mux2_sel(ie_mux2_sel),
      .id_flush(id_flush), .ie_flush(ie_flush), .stall(stall),
      .state(state), .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] opc;
      logic [2:0] f3;
      logic [5:0] flags;   // {eq,neq,lt,ge,ltu,geu}
      logic [4:0] rs1, rs2, rd;
      logic       ld;
      logic [6:0] exp;     // {branch,stall,pc_en,id_flush,ie_flush,mux1,mux2}
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic logic [6:0] run_outs();
      return {branch, stall, pc_en, id_flush, ie_flush, ie_mux1_sel, ie_mux2_sel};
   endfunction

   task automatic clear_ie();
      ie_opcode = 7'd0; ie_funct3 = 3'd0; ie_is_load = 1'b0;
      id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ie_rd_addr = 5'd0;
      {eq_flag, neq_flag, lt_flag, ge_flag, ltu_flag, geu_flag} = 6'd0;
   endtask

   task automatic enter_load();
      @(negedge clk); ldr.load_req = 1'b1;
      @(negedge clk); ldr.load_req = 1'b0;
   endtask

   initial begin
      int errs;
      vecs[0]  = '{OPC_LOAD,   3'b000, 6'b000000, 5'd5, 5'd1, 5'd5, 1'b1, 7'b0100101};
      vecs[1]  = '{OPC_LOAD,   3'b000, 6'b000000, 5'd2, 5'd5, 5'd5, 1'b1, 7'b0100101};
      vecs[2]  = '{OPC_LOAD,   3'b000, 6'b000000, 5'd0, 5'd0, 5'd0, 1'b1, 7'b0010001};
      vecs[3]  = '{OPC_OP,     3'b000, 6'b000000, 5'd5, 5'd5, 5'd5, 1'b0, 7'b0010000};
      vecs[4]  = '{OPC_BRANCH, 3'b000, 6'b100000, 5'd1, 5'd2, 5'd3, 1'b0, 7'b1011111};
      vecs[5]  = '{OPC_BRANCH, 3'b000, 6'b011111, 5'd1, 5'd2, 5'd3, 1'b0, 7'b0010011};
      vecs[6]  = '{OPC_BRANCH, 3'b110, 6'b000010, 5'd1, 5'd2, 5'd3, 1'b0, 7'b1011111};
      vecs[7]  = '{OPC_BRANCH, 3'b110, 6'b111101, 5'd1, 5'd2, 5'd3, 1'b0, 7'b0010011};
      vecs[8]  = '{OPC_BRANCH, 3'b001, 6'b010000, 5'd1, 5'd2, 5'd3, 1'b0, 7'b1011111};
      vecs[9]  = '{OPC_BRANCH, 3'b010, 6'b111111, 5'd1, 5'd2, 5'd3, 1'b0, 7'b0010011};
      vecs[10] = '{OPC_JALR,   3'b000, 6'b000000, 5'd1, 5'd2, 5'd3, 1'b0, 7'b1011101};
      vecs[11] = '{OPC_AUIPC,  3'b000, 6'b000000, 5'd1, 5'd2, 5'd3, 1'b0, 7'b0010011};
      vecs[12] = '{OPC_BRANCH, 3'b100, 6'b001000, 5'd5, 5'd1, 5'd5, 1'b1, 7'b1011111};
      vecs[13] = '{OPC_BRANCH, 3'b111, 6'b000001, 5'd1, 5'd2, 5'd3, 1'b0, 7'b1011111};
      vecs[14] = '{OPC_BRANCH, 3'b101, 6'b000100, 5'd1, 5'd2, 5'd3, 1'b0, 7'b1011111};
      vecs[15] = '{OPC_JAL,    3'b000, 6'b000000, 5'd1, 5'd2, 5'd3, 1'b0, 7'b1011111};
      vecs[16] = '{OPC_BRANCH, 3'b100, 6'b110111, 5'd1, 5'd2, 5'd3, 1'b0, 7'b0010011};

      rst_n = 1'b0; halt_req = 1'b0;
      ldr.load_req = 1'b0; ldr.load_valid = 1'b0; ldr.load_last = 1'b0;
      clear_ie();
      #12;
      check("rst_state", 64'(state), 64'(ST_IDLE));
      check("rst_addr", 64'(ldr.load_addr), 64'd0);
      check("rst_enables", 64'({pc_en, imem_en, imem_ld, rf_en, branchcmp_en, ldr.load_ready, ldr.load_done}), 64'd0);
      check("rst_flags", 64'({branch, stall, id_flush, ie_flush}), 64'd0);
      check("rst_mux", 64'({ie_mux1_sel, ie_mux2_sel}), 64'b01);
      check("rst_perf", 64'({perf_stalls, perf_flushes}), 64'd0);
      @(negedge clk); rst_n = 1'b1;

      // Four-word boot load terminated by load_last.
      enter_load();
      #1;
      check("load_state", 64'(state), 64'(ST_LOAD));
      check("load_ctrl", 64'({ldr.load_ready, imem_ld, imem_en}), 64'b111);
      for (int i = 0; i < 4; i++) begin
         ldr.load_valid = 1'b1; ldr.load_last = (i == 3);
         #1;
         check("load_addr", 64'(ldr.load_addr), 64'(i));
         check("load_done_early", 64'(ldr.load_done), 64'd0);
         @(negedge clk);
      end
      ldr.load_valid = 1'b0; ldr.load_last = 1'b0;
      #1;
      check("run_state", 64'(state), 64'(ST_RUN));
      check("load_done_pulse", 64'(ldr.load_done), 64'd1);
      check("run_enables", 64'({imem_en, rf_en, branchcmp_en, imem_ld}), 64'b1110);
      @(negedge clk); #1;
      check("load_done_clear", 64'(ldr.load_done), 64'd0);

      // Hazard / branch table in RUN.
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         ie_opcode = vecs[i].opc; ie_funct3 = vecs[i].f3;
         {eq_flag, neq_flag, lt_flag, ge_flag, ltu_flag, geu_flag} = vecs[i].flags;
         id_rs1_addr = vecs[i].rs1; id_rs2_addr = vecs[i].rs2;
         ie_rd_addr = vecs[i].rd; ie_is_load = vecs[i].ld;
         #1;
         check($sformatf("vec%0d", i), 64'(run_outs()), 64'(vecs[i].exp));
      end

      // halt_req together with a taken JAL, then drain and halt.
      @(negedge clk);
      clear_ie(); ie_opcode = OPC_JAL; halt_req = 1'b1;
      #1;
      check("halt_jal", 64'({branch, pc_en, id_flush, ie_flush}), 64'b1111);
      @(negedge clk);
      halt_req = 1'b0; clear_ie();
      for (int i = 0; i < DRAIN_CYCLES; i++) begin
         #1;
         check("drain_state", 64'(state), 64'(ST_DRAIN));
         check("drain_en", 64'({pc_en, imem_en, rf_en, branch}), 64'b0010);
         @(negedge clk);
      end
      #1;
      check("halt_state", 64'(state), 64'(ST_HALT));
      check("halt_en", 64'({pc_en, imem_en, imem_ld, rf_en, branchcmp_en}), 64'd0);
      halt_req = 1'b1;
      @(negedge clk); halt_req = 1'b0; #1;
      check("halt_ignore", 64'(state), 64'(ST_HALT));

      // Re-enter LOAD from HALT and stream a full IMEM image.
      enter_load();
      #1;
      check("reload_state", 64'(state), 64'(ST_LOAD));
      errs = 0;
      for (int i = 0; i < IMEM_DEPTH; i++) begin
         ldr.load_valid = 1'b1;
         #1;
         if (state !== ST_LOAD || ldr.load_addr !== ADDR_W'(i)) errs++;
         @(negedge clk);
      end
      ldr.load_valid = 1'b0;
      check("stream_addr_errs", 64'(errs), 64'd0);
      #1;
      check("stream_exit", 64'({state, ldr.load_done}), 64'({ST_RUN, 1'b1}));

      // Reset asserted mid-LOAD at address 10.
      @(negedge clk); halt_req = 1'b1;
      @(negedge clk); halt_req = 1'b0;
      repeat (DRAIN_CYCLES) @(negedge clk);
      enter_load();
      for (int i = 0; i < 10; i++) begin
         ldr.load_valid = 1'b1;
         @(negedge clk);
      end
      #1;
      check("pre_rst_addr", 64'({ldr.load_addr, imem_ld}), 64'({11'd10, 1'b1}));
      rst_n = 1'b0;
      #1;
      check("async_imem_ld", 64'(imem_ld), 64'd0);
      check("async_addr", 64'(ldr.load_addr), 64'd0);
      check("async_state", 64'(state), 64'(ST_IDLE));
      check("async_perf", 64'({perf_stalls, perf_flushes}), 64'd0);
      ldr.load_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
